// File: rtl/branch_resolve_if.sv
// Control-flow resolve bundle: upstream op, downstream result,
// flush pulse and performance counters.
interface branch_resolve_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_branch;
    logic        in_is_jal;
    logic        in_is_jalr;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic [31:0] in_rs1;
    logic [31:0] cmp_res;
    logic        out_valid;
    logic        out_ready;
    logic        out_redirect;
    logic [31:0] out_target;
    logic [31:0] out_link;
    logic        out_misalign;
    logic        flush;
    logic [31:0] br_cnt;
    logic [31:0] taken_cnt;

    modport master (
        output in_valid, in_is_branch, in_is_jal, in_is_jalr,
        output in_pc, in_imm, in_rs1, cmp_res, out_ready,
        input  in_ready, out_valid, out_redirect, out_target,
        input  out_link, out_misalign, flush, br_cnt, taken_cnt
    );

    modport slave (
        input  in_valid, in_is_branch, in_is_jal, in_is_jalr,
        input  in_pc, in_imm, in_rs1, cmp_res, out_ready,
        output in_ready, out_valid, out_redirect, out_target,
        output out_link, out_misalign, flush, br_cnt, taken_cnt
    );
endinterface

// File: rtl/branch_resolve.sv
// Resolves branch/jal/jalr ops into a redirect, target and link,
// with a one-cycle flush pulse after each taken redirect.
module branch_resolve (
    input  logic             clk,
    input  logic             rst_n,
    branch_resolve_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_t;

    state_t      r_state;
    logic        r_valid;
    logic        r_redirect;
    logic        r_misalign;
    logic        r_flush;
    logic [31:0] r_target;
    logic [31:0] r_link;
    logic [31:0] r_br_cnt;
    logic [31:0] r_taken_cnt;

    logic        w_jalr;
    logic        w_jal;
    logic        w_br;
    logic        w_br_tk;
    logic        w_taken;
    logic [31:0] w_target;
    logic        w_misalign;
    logic        w_redirect;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_hs;

    // Type bits are masked so jalr > jal > branch and selects are one-hot
    assign w_jalr     = bus.in_is_jalr;
    assign w_jal      = bus.in_is_jal & ~bus.in_is_jalr;
    assign w_br       = bus.in_is_branch & ~bus.in_is_jal
                        & ~bus.in_is_jalr;
    assign w_br_tk    = w_br & bus.cmp_res[0];
    assign w_taken    = w_jalr | w_jal | w_br_tk;

    always_comb begin
        w_target = bus.in_pc + 32'd4;
        unique case (1'b1)
            w_jalr:  w_target = (bus.in_rs1 + bus.in_imm)
                                & 32'hFFFF_FFFE;
            w_jal:   w_target = bus.in_pc + bus.in_imm;
            w_br_tk: w_target = bus.in_pc + bus.in_imm;
            default: w_target = bus.in_pc + 32'd4;
        endcase
    end

    assign w_misalign = w_taken & w_target[1];
    assign w_redirect = w_taken & ~w_misalign;

    always_comb begin
        w_in_ready = 1'b0;
        unique case (r_state)
            IDLE:    w_in_ready = 1'b1;
            HOLD:    w_in_ready = bus.out_ready & ~r_redirect;
            FLUSH:   w_in_ready = 1'b0;
            default: w_in_ready = 1'b0;
        endcase
    end

    assign w_accept = bus.in_valid & w_in_ready;
    assign w_hs     = r_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_valid     <= 1'b0;
            r_redirect  <= 1'b0;
            r_misalign  <= 1'b0;
            r_flush     <= 1'b0;
            r_target    <= 32'd0;
            r_link      <= 32'd0;
            r_br_cnt    <= 32'd0;
            r_taken_cnt <= 32'd0;
        end else begin
            r_flush <= 1'b0;
            if (w_accept) begin
                r_br_cnt    <= r_br_cnt + 32'(w_br);
                r_taken_cnt <= r_taken_cnt + 32'(w_taken);
            end
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state    <= HOLD;
                        r_valid    <= 1'b1;
                        r_redirect <= w_redirect;
                        r_misalign <= w_misalign;
                        r_target   <= w_target;
                        r_link     <= bus.in_pc + 32'd4;
                    end
                end
                HOLD: begin
                    if (w_hs) begin
                        if (r_redirect) begin
                            r_state    <= FLUSH;
                            r_valid    <= 1'b0;
                            r_redirect <= 1'b0;
                            r_flush    <= 1'b1;
                        end else if (w_accept) begin
                            r_redirect <= w_redirect;
                            r_misalign <= w_misalign;
                            r_target   <= w_target;
                            r_link     <= bus.in_pc + 32'd4;
                        end else begin
                            r_state    <= IDLE;
                            r_valid    <= 1'b0;
                            r_redirect <= 1'b0;
                        end
                    end
                end
                FLUSH: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_valid;
    assign bus.out_redirect = r_redirect;
    assign bus.out_misalign = r_misalign;
    assign bus.out_target   = r_target;
    assign bus.out_link     = r_link;
    assign bus.flush        = r_flush;
    assign bus.br_cnt       = r_br_cnt;
    assign bus.taken_cnt    = r_taken_cnt;
endmodule
